// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: op selectors, R-type function codes, FSM states.
package alu_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;
  localparam logic [5:0] FUNCT_DIV = 6'b011010;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add multiply and restoring divide, one step per cycle over WIDTH steps,
// sharing one WIDTH+1-bit adder. done/result are valid combinationally during the last step.
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, lo_q, b_q, hi_d, lo_d;
  logic             div_q, busy_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   div_shift, add_x, add_y;
  logic [WIDTH+1:0] sum;
  logic             ge;

  // Divide: {hi,lo} = {remainder, dividend/quotient}; multiply: {hi,lo} = {partial, multiplier}.
  always_comb begin
    div_shift = {hi_q, lo_q[WIDTH-1]};
    add_x     = div_q ? div_shift : {1'b0, hi_q};
    add_y     = div_q ? ~{1'b0, b_q} : (lo_q[0] ? {1'b0, b_q} : '0);
    sum       = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, div_q};
    ge        = sum[WIDTH+1];
    if (div_q) begin
      hi_d = ge ? sum[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign busy   = busy_q;
  assign done   = busy_q && (cnt_q == CW'(WIDTH-1));
  assign result = {hi_d, lo_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      hi_q   <= '0;
      lo_q   <= a;
      b_q    <= b;
      div_q  <= is_div;
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: valid/ready handshake FSM, single-cycle ops and flags; MUL/DIV go to the
// iterative engine.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHW-1:0]     shamt,
  input  logic [5:0]         funct,
  input  logic [1:0]         alu_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               div_by_zero
);
  state_e             state_q;
  logic [2*WIDTH-1:0] result_q;
  logic               zero_q, dbz_q;

  logic [5:0]         eff_fn;
  logic               is_mul, is_div, b_zero, accept, md_start;
  logic [WIDTH-1:0]   lo, hi;
  logic               md_busy, md_done;
  logic [2*WIDTH-1:0] md_res;

  always_comb begin
    case (alu_op)
      ALU_OP_ADD: eff_fn = FUNCT_ADD;
      ALU_OP_SUB: eff_fn = FUNCT_SUB;
      default:    eff_fn = funct;
    endcase
  end

  assign is_mul   = (eff_fn == FUNCT_MUL);
  assign is_div   = (eff_fn == FUNCT_DIV);
  assign b_zero   = (b == '0);
  assign accept   = in_valid && (state_q == IDLE);
  assign md_start = accept && (is_mul || (is_div && !b_zero));

  // Single-cycle results; divide-by-zero lands here too, MUL and real DIV never use it.
  always_comb begin
    lo = '0;
    hi = '0;
    case (eff_fn)
      FUNCT_ADD: lo = a + b;
      FUNCT_SUB: lo = a - b;
      FUNCT_SLL: lo = a << shamt;
      FUNCT_SRL: lo = a >> shamt;
      FUNCT_OR:  lo = a | b;
      FUNCT_AND: lo = a & b;
      FUNCT_NOR: lo = ~(a | b);
      FUNCT_XOR: lo = a ^ b;
      FUNCT_DIV: begin lo = '1; hi = a; end
      default:   ;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (is_div),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          dbz_q <= 1'b0;
          if (md_start) begin
            state_q <= CALC;
          end else begin
            result_q <= {hi, lo};
            zero_q   <= ({hi, lo} == '0);
            dbz_q    <= is_div;
            state_q  <= DONE;
          end
        end
        CALC: if (md_busy && md_done) begin
          result_q <= md_res;
          zero_q   <= (md_res == '0);
          state_q  <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed check of alu_seq (WIDTH=16) against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  a = '0, b = '0;
  logic [3:0]    shamt = '0;
  logic [5:0]    funct = '0;
  logic [1:0]    alu_op = '0;
  logic          in_ready, out_valid, zero, div_by_zero;
  logic [2*W-1:0] result;

  int n_vec = 0, n_err = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .shamt(shamt), .funct(funct), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [15:0] x,
                       input logic [15:0] y, input logic [3:0] sh,
                       output logic [31:0] r, output logic d, output int lat);
    logic [5:0] f;
    logic [31:0] xx, yy;
    f  = (op == 2'b00) ? 6'b100000 : (op == 2'b01) ? 6'b100010 : fn;
    xx = {16'h0, x};
    yy = {16'h0, y};
    r = 32'h0; d = 1'b0; lat = 1;
    case (f)
      6'b100000: r = (xx + yy) & 32'hFFFF;
      6'b100010: r = (xx - yy) & 32'hFFFF;
      6'b011000: begin r = xx * yy; lat = 17; end
      6'b011010: if (y == 0) begin r = {x, 16'hFFFF}; d = 1'b1; end
                 else begin r = ((xx % yy) << 16) | (xx / yy); lat = 17; end
      6'b000000: r = (xx << sh) & 32'hFFFF;
      6'b000010: r = xx >> sh;
      6'b100101: r = xx | yy;
      6'b100100: r = xx & yy;
      6'b100111: r = ~(xx | yy) & 32'hFFFF;
      6'b100110: r = xx ^ yy;
      default:   r = 32'h0;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                        input logic [15:0] x, input logic [15:0] y, input logic [3:0] sh,
                        input int hold);
    logic [31:0] er;
    logic        ed, rdy_seen;
    int          el, lat;
    model(op, fn, x, y, sh, er, ed, el);
    @(negedge clk);
    alu_op = op; funct = fn; a = x; b = y; shamt = sh; in_valid = 1'b1;
    chk({tag, ":in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); shamt = 4'($urandom);
    lat = 1; rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ":latency"}, 64'(lat), 64'(el));
    chk({tag, ":result"}, 64'(result), 64'(er));
    chk({tag, ":zero"}, 64'(zero), 64'(er == 32'h0));
    chk({tag, ":dbz"}, 64'(div_by_zero), 64'(ed));
    chk({tag, ":busy_rdy"}, 64'(rdy_seen), 64'd0);
    if (hold > 0) begin
      in_valid = 1'b1; alu_op = 2'b00; a = 16'h1; b = 16'h1;
      repeat (hold) begin @(posedge clk); #1; end
      chk({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ":hold_result"}, 64'(result), 64'(er));
      chk({tag, ":hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk({tag, ":drain_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ":drain_rdy"}, 64'(in_ready), 64'd1);
  endtask

  logic [5:0] fn_tab [10] = '{6'b100000, 6'b100010, 6'b011000, 6'b011010, 6'b000000,
                             6'b000010, 6'b100101, 6'b100100, 6'b100111, 6'b100110};

  initial begin
    #12;
    chk("rst:in_ready", 64'(in_ready), 64'd1);
    chk("rst:out_valid", 64'(out_valid), 64'd0);
    chk("rst:result", 64'(result), 64'd0);
    chk("rst:zero", 64'(zero), 64'd0);
    chk("rst:dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset while the multiplier is mid-run
    @(negedge clk);
    alu_op = 2'b10; funct = 6'b011000; a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst:out_valid", 64'(out_valid), 64'd0);
    chk("midrst:in_ready", 64'(in_ready), 64'd1);
    chk("midrst:result", 64'(result), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add_wrap", 2'b00, 6'h3F, 16'hFFFF, 16'h0001, 4'd0, 0);
    run_op("mul_max", 2'b10, 6'b011000, 16'hFFFF, 16'hFFFF, 4'd0, 0);
    run_op("div_100_7", 2'b10, 6'b011010, 16'd100, 16'd7, 4'd0, 0);
    run_op("div_by0", 2'b10, 6'b011010, 16'h1234, 16'h0000, 4'd0, 0);
    run_op("srl_bp", 2'b10, 6'b000010, 16'h8000, 16'h0000, 4'd15, 4);
    run_op("sub_zero", 2'b01, 6'h00, 16'd5, 16'd5, 4'd0, 0);
    run_op("or_nz", 2'b10, 6'b100101, 16'h00F0, 16'h0F00, 4'd0, 0);
    run_op("op11_xor", 2'b11, 6'b100110, 16'hA5A5, 16'h0F0F, 4'd0, 0);
    run_op("undef", 2'b10, 6'b111111, 16'h1234, 16'h5678, 4'd0, 1);
    run_op("div_small", 2'b10, 6'b011010, 16'd3, 16'd9, 4'd0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [15:0] x, y;
      op = 2'($urandom_range(0, 3));
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 9)];
      x  = 16'($urandom);
      y  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run_op("rand", op, fn, x, y, 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised multi-cycle successor to the single-cycle ALU.
- Covers the same ALUOp/funct operation set at configurable WIDTH.
- Replaces combinational multiply and divide with iterative shift-add and restoring-divide engines; adds a valid/ready handshake on both sides.
- Sits between register-file read and write-back in the multi-cycle datapath.

Parameters:
- WIDTH, 16: operand width in bits (>=4, power of two).
- SHW, $clog2(WIDTH): shift-amount width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned).
- shamt  in  SHW  shift amount.
- funct  in  6  R-type function code.
- alu_op  in  2  00=add, 01=sub, 10=decode funct.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer takes the result.
- result  out  2*WIDTH  result; see width rules.
- zero  out  1  result == 0 over all 2*WIDTH bits.
- div_by_zero  out  1  last DIV had b == 0.

Behaviour:
- Reset (async, rst_n low): state=IDLE; in_ready=1; out_valid=0; result=0; zero=0; div_by_zero=0. Reset mid-CALC aborts the operation; no partial result becomes visible.
- States:
  - IDLE: on in_valid&&in_ready, latch inputs. MUL or DIV with b!=0 -> CALC. All other ops -> DONE, with result computed and registered at that edge.
  - CALC: one iteration per cycle, WIDTH iterations. On the last iteration, register result -> DONE.
  - DONE: out_valid=1; result, zero and div_by_zero held stable. On out_ready -> IDLE. in_ready stays 0 in this cycle, so there is no same-cycle accept.
- Latency, from accept edge to out_valid: 1 cycle for simple ops and for DIV by zero; WIDTH+1 cycles for MUL and DIV.
- Ops and width rules (all unsigned):
  - alu_op=00 add, alu_op=01 sub.
  - alu_op=10, funct: 100000 add; 100010 sub; 011000 mul; 011010 div; 000000 sll; 000010 srl; 100101 or; 100100 and; 100111 nor; 100110 xor.
  - add/sub/logic/shift: low WIDTH bits hold the modulo-2^WIDTH result; upper WIDTH bits are 0.
  - sll/srl are logical, shifting a by shamt; zeros fill.
  - mul: full 2*WIDTH product.
  - div: quotient in result[WIDTH-1:0], remainder in result[2*WIDTH-1:WIDTH].
  - DIV with b==0: quotient all ones, remainder=a, div_by_zero=1.
  - Undefined funct: result=0 (so zero=1), 1-cycle latency.
- Flags:
  - zero is recomputed on every completed op and is never sticky.
  - div_by_zero is cleared on every accept and set only as above.
- alu_op=11 is treated as 10.
- Inputs are ignored outside IDLE. Operands are latched, so changing a/b during CALC has no effect.

Decomposition:
- Shared package alu_pkg: ALU_OP_* constants (2-bit); FUNCT_* constants (6-bit) for all ten ops; state enum {IDLE, CALC, DONE}.
- One sub-module, alu_muldiv_iter (params WIDTH): start, is_div, a, b -> busy, done, 2*WIDTH result. Holds the shift-add multiplier and the restoring divider sharing one WIDTH+1-bit adder and iteration counter.
- The top holds the handshake FSM, single-cycle ops, and flag logic.

Test Plan (WIDTH=16):
- Reset mid-MUL: rst_n low at CALC cycle 5 -> out_valid=0, in_ready=1 immediately; the next op completes normally.
- add 0xFFFF+0x0001 (alu_op=00) -> out_valid one cycle after accept; result=0x00000000; zero=1.
- mul 0xFFFF*0xFFFF -> out_valid 17 cycles after accept; result=0xFFFE0001; in_ready=0 throughout.
- div 100/7 -> result=0x0002000E (rem 2, quot 14); div_by_zero=0. Then div 0x1234/0 -> result=0x1234FFFF; div_by_zero=1; 1-cycle latency.
- Backpressure: srl 0x8000 shamt=15 with out_ready=0 for 4 cycles -> result=0x00000001 held stable, in_valid ignored; accepted only in the cycle after out_ready.
- Back-to-back: sub 5-5 (zero=1), then or 0x00F0|0x0F00 -> second result=0x00000FF0 with zero=0, confirming zero is not sticky.
